// File: rtl/admm_iteration_scheduler.sv
// rtl/admm_iteration_scheduler.sv - ADMM iteration sequencer: primal/slack/dual stages,
// periodic residual checks, abort drain and z / z_prev bank select.
module admm_iteration_scheduler #(
  parameter int ITER_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ITER_WIDTH-1:0] max_iter,
  input  logic [ITER_WIDTH-1:0] check_interval,
  output logic                  primal_start,
  output logic                  slack_start,
  output logic                  dual_start,
  output logic                  res_start,
  input  logic                  primal_done,
  input  logic                  slack_done,
  input  logic                  dual_done,
  input  logic                  res_done,
  input  logic                  res_converged,
  output logic                  z_bank,
  output logic [ITER_WIDTH-1:0] iter_count,
  output logic                  busy,
  output logic                  done,
  output logic                  converged,
  output logic                  aborted
);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_PRI_REQ,
    ST_PRI_REL,
    ST_SLK_REQ,
    ST_SLK_REL,
    ST_DUA_REQ,
    ST_DUA_REL,
    ST_RES_REQ,
    ST_RES_REL,
    ST_DRAIN,
    ST_FINISH
  } state_t;

  state_t state, state_nxt;

  logic [ITER_WIDTH-1:0] max_q, max_nxt;
  logic [ITER_WIDTH-1:0] intv_q, intv_nxt;
  logic [ITER_WIDTH-1:0] chk_q, chk_nxt;
  logic [ITER_WIDTH-1:0] iter_nxt;
  logic [ITER_WIDTH-1:0] iter_inc;
  logic [ITER_WIDTH-1:0] chk_inc;
  logic                  chk_wrap;
  logic                  z_nxt;
  logic                  conv_nxt;
  logic                  abrt_nxt;
  logic                  flag_q, flag_nxt;
  logic                  in_stage;
  logic                  any_done;

  assign iter_inc = (iter_count == '1) ? iter_count : iter_count + ITER_WIDTH'(1);
  assign chk_inc  = chk_q + ITER_WIDTH'(1);
  assign chk_wrap = (chk_inc == intv_q);
  assign any_done = primal_done | slack_done | dual_done | res_done;

  always_comb begin
    in_stage = 1'b0;
    case (state)
      ST_PRI_REQ, ST_PRI_REL, ST_SLK_REQ, ST_SLK_REL,
      ST_DUA_REQ, ST_DUA_REL, ST_RES_REQ, ST_RES_REL: in_stage = 1'b1;
      default:                                        in_stage = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    max_nxt   = max_q;
    intv_nxt  = intv_q;
    chk_nxt   = chk_q;
    iter_nxt  = iter_count;
    z_nxt     = z_bank;
    conv_nxt  = converged;
    abrt_nxt  = aborted;
    flag_nxt  = flag_q;

    // Abort wins over any handshake progress made in the same cycle.
    if (in_stage && abort) begin
      state_nxt = ST_DRAIN;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            max_nxt   = max_iter;
            intv_nxt  = (check_interval == '0) ? ITER_WIDTH'(1) : check_interval;
            chk_nxt   = '0;
            iter_nxt  = '0;
            conv_nxt  = 1'b0;
            abrt_nxt  = 1'b0;
            state_nxt = (max_iter == '0) ? ST_FINISH : ST_PRI_REQ;
          end
        end
        ST_PRI_REQ: if (primal_done)  state_nxt = ST_PRI_REL;
        ST_PRI_REL: if (!primal_done) state_nxt = ST_SLK_REQ;
        ST_SLK_REQ: if (slack_done)   state_nxt = ST_SLK_REL;
        ST_SLK_REL: if (!slack_done)  state_nxt = ST_DUA_REQ;
        ST_DUA_REQ: if (dual_done)    state_nxt = ST_DUA_REL;
        ST_DUA_REL: begin
          if (!dual_done) begin
            // Iteration complete: the freshly written z bank becomes current.
            iter_nxt  = iter_inc;
            z_nxt     = ~z_bank;
            chk_nxt   = chk_wrap ? '0 : chk_inc;
            state_nxt = (chk_wrap || (iter_inc == max_q)) ? ST_RES_REQ : ST_PRI_REQ;
          end
        end
        ST_RES_REQ: begin
          if (res_done) begin
            flag_nxt  = res_converged;
            state_nxt = ST_RES_REL;
          end
        end
        ST_RES_REL: begin
          if (!res_done) begin
            if (flag_q) begin
              conv_nxt  = 1'b1;
              state_nxt = ST_FINISH;
            end else if (iter_count == max_q) begin
              state_nxt = ST_FINISH;
            end else begin
              state_nxt = ST_PRI_REQ;
            end
          end
        end
        ST_DRAIN: begin
          if (!any_done) begin
            abrt_nxt  = 1'b1;
            conv_nxt  = 1'b0;
            state_nxt = ST_FINISH;
          end
        end
        ST_FINISH: state_nxt = ST_IDLE;
        default:   state_nxt = ST_IDLE;
      endcase
    end
  end

  // Stage requests are decoded from the next state so they leave a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      max_q        <= '0;
      intv_q       <= ITER_WIDTH'(1);
      chk_q        <= '0;
      flag_q       <= 1'b0;
      iter_count   <= '0;
      z_bank       <= 1'b0;
      converged    <= 1'b0;
      aborted      <= 1'b0;
      primal_start <= 1'b0;
      slack_start  <= 1'b0;
      dual_start   <= 1'b0;
      res_start    <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state        <= state_nxt;
      max_q        <= max_nxt;
      intv_q       <= intv_nxt;
      chk_q        <= chk_nxt;
      flag_q       <= flag_nxt;
      iter_count   <= iter_nxt;
      z_bank       <= z_nxt;
      converged    <= conv_nxt;
      aborted      <= abrt_nxt;
      primal_start <= (state_nxt == ST_PRI_REQ);
      slack_start  <= (state_nxt == ST_SLK_REQ);
      dual_start   <= (state_nxt == ST_DUA_REQ);
      res_start    <= (state_nxt == ST_RES_REQ);
      busy         <= (state_nxt != ST_IDLE);
      done         <= (state == ST_FINISH);
    end
  end

endmodule

// File: doc/admm_iteration_scheduler.md
# admm_iteration_scheduler

Top-level ADMM iteration sequencer for the MPC solver. It runs the primal update, slack update and dual update stages in order for each iteration. Every `check_interval` iterations, and always on the last allowed iteration, it runs the residual calculator and stops on convergence or when `max_iter` is reached. It also owns the z / z_prev ping-pong bank select, so no copy of z is needed between iterations.

## Interface
- `ITER_WIDTH`, 16, width of iteration counters and limits
- `clk` in 1: system clock, all logic on rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `start` in 1: solve request, sampled only in IDLE
- `abort` in 1: synchronous abort, sampled in any non-IDLE state
- `max_iter` in ITER_WIDTH: iteration limit, sampled at accepted start
- `check_interval` in ITER_WIDTH: residual-check period, sampled at accepted start; 0 treated as 1
- `primal_start` / `slack_start` / `dual_start` / `res_start` out 1: stage requests
- `primal_done` / `slack_done` / `dual_done` / `res_done` in 1: stage completions
- `res_converged` in 1: residual calculator convergence flag, valid while `res_done`=1
- `z_bank` out 1: bank holding the current z; z_prev is `!z_bank`
- `iter_count` out ITER_WIDTH: completed iterations in the current or last solve
- `busy` out 1: high in every state except IDLE
- `done` out 1: one-cycle pulse when a solve ends
- `converged` out 1: result of the last solve, held until the next accepted start
- `aborted` out 1: last solve ended by abort, held until the next accepted start

## Operation
- **Stage handshake (4-phase):**
  - Stage REQ state: drive that stage's `*_start`=1 and wait for `*_done`=1.
  - Stage REL state: drive `*_start`=0 and wait for `*_done`=0.
  - Only one `*_start` is ever high at a time.
- **States:** IDLE, PRI_REQ, PRI_REL, SLK_REQ, SLK_REL, DUA_REQ, DUA_REL, RES_REQ, RES_REL, DRAIN, FINISH.
- **IDLE:**
  - On `start`=1: latch limits, clear `iter_count`, `converged` and `aborted`, reset the check counter.
  - If latched `max_iter`==0, go to FINISH. Otherwise go to PRI_REQ.
- **PRI, SLK and DUA stages:** run in that order.
- **DUA_REL exit:**
  - `iter_count`+1 and `z_bank` toggles in the same cycle.
  - Check counter +1; if it equals the interval, the counter resets to 0.
  - Go to RES_REQ if the check counter wrapped or the new `iter_count`==`max_iter`. Otherwise go to PRI_REQ.
- **RES_REQ:** capture `res_converged` on the cycle `res_done`=1.
- **RES_REL exit:**
  - If the captured flag is 1, set `converged`=1 and go to FINISH.
  - Else if `iter_count`==`max_iter`, go to FINISH with `converged`=0.
  - Else go to PRI_REQ.
- **FINISH:** pulse `done` for 1 cycle, then return to IDLE.
- **Abort:**
  - `abort`=1 in any REQ or REL state: all `*_start` drop next cycle, state goes to DRAIN.
  - DRAIN waits until all four `*_done`=0, then goes to FINISH with `aborted`=1 and `converged`=0.
  - Abort has priority over stage progress in the same cycle.
  - `iter_count` is not incremented on the aborted iteration.
- **Counters:** `iter_count` saturates at all-ones. A `start` while busy is ignored.

## Timing
- **Reset values** (while `rst_n`=0, asynchronous): state IDLE; all `*_start`=0, `busy`=0, `done`=0, `converged`=0, `aborted`=0, `z_bank`=0, `iter_count`=0.
- **All outputs are registered.**
- **Start to first request:** `start` sampled at edge E makes `primal_start`=1 and `busy`=1 after E.
- **Done to release:** `*_done` sampled high at edge E drops `*_start` after E.
- **Release to next request:** `*_done` sampled low at edge E raises the next stage's `*_start` after E.
- **Minimum overhead:** 2 cycles per stage beyond sub-block latency.
- **`max_iter`==0:** `done` pulses 2 cycles after start with `iter_count`=0.
- **`done` and flags:** `done` is high for exactly 1 cycle. `converged` and `aborted` are valid in the cycle of `done` and hold afterwards.
- **Reset mid-solve:** immediate return to reset values; sub-blocks see `*_start`=0.

## Test plan
- **Convergence on first check:** `max_iter`=10, `check_interval`=3, stubs (3-cycle done), `res_converged`=1 on the first check → RES runs after iteration 3; `done` with `converged`=1, `iter_count`=3, `z_bank`=1.
- **Iteration limit:** `max_iter`=5, `check_interval`=2, `res_converged`=0 → checks after iterations 2, 4 and 5 (forced); `done` with `converged`=0, `iter_count`=5; stage order is PRI, SLK, DUA, never overlapping.
- **Zero limits:** `max_iter`=0 → `done` 2 cycles after start, no `*_start` ever high. Separately, `check_interval`=0, `max_iter`=2 → checks after every iteration.
- **Abort mid-stage:** abort during SLK_REQ of iteration 2 while `slack_done` is held high 4 more cycles → `slack_start` drops next cycle, `done` follows only after `slack_done`=0; `aborted`=1, `iter_count`=1.
- **Handshake stall and ignored start:** `dual_done` stays high 6 cycles after `dual_start` drops → no `res_start` or `primal_start` until it falls. `start` pulsed while busy has no effect.
- **Async reset mid-solve:** `rst_n` low during DUA_REQ → all outputs at reset values within the same cycle; a fresh start then proceeds normally.
